// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and
// a constant helper used to size the cycle counter.
package rst_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_EXT  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_RSVD = 2'b11
  } cause_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stdsync.sv
// N-stage single-bit synchroniser; all stages load RST_VAL while rst is high.
module stdsync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all channels in reset for HOLD_CYCLES after the last
// request, then releases channel 0..NCH-1 in order, GAP_CYCLES apart.
module rst_seq
  import rst_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ext_rst_n,
  input  logic           sw_rst_req,
  output logic [NCH-1:0] o_rst_n,
  output logic           o_busy,
  output logic           o_done,
  output logic [1:0]     o_cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1) begin : g_bad_nch
    $error("rst_seq: NCH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("rst_seq: GAP_CYCLES must be >= 1");
  end

  logic sync_ext_n;

  stdsync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_ext_sync (
    .clk(clk),
    .rst(rst),
    .d  (ext_rst_n),
    .q  (sync_ext_n)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NCH-1:0]   rst_n_q, rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  cause_e           cause_q, cause_d;
  // Set once the synchroniser has shown a released input since rst; until then a
  // low synchroniser output is only its own reset value, so the cause stays POR.
  logic             armed_q, armed_d;

  logic ext_req;
  logic req;

  always_comb begin
    ext_req = ~sync_ext_n;
    req     = ext_req | sw_rst_req;

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    cause_d = cause_q;
    armed_d = armed_q | sync_ext_n;

    if (req) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      if (ext_req && armed_q) begin
        cause_d = CAUSE_EXT;
      end else if (sw_rst_req) begin
        cause_d = CAUSE_SW;
      end
    end else begin
      unique case (state_q)
        ASSERT: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d      = '0;
            rst_n_d[0] = 1'b1;
            if (NCH == 1) begin
              state_d = RUN;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_d   = '0;
            rst_n_d = rst_n_q | (NCH'(1) << idx_q);
            if (idx_q == IDX_W'(NCH - 1)) begin
              state_d = RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          rst_n_d = '1;
        end
        default: begin
          state_d = ASSERT;
          rst_n_d = '0;
        end
      endcase
    end

    done_d = (state_d == RUN);
    busy_d = ~done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      armed_q <= armed_d;
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a timing model derived from "edges since the last
// request" predicts every output of a default and a single-channel instance.
module tb_rst_seq;

  localparam int SYNC = 2;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;

  logic [2:0] rn0;
  logic       busy0, done0;
  logic [1:0] cause0;
  logic [0:0] rn1;
  logic       busy1, done1;
  logic [1:0] cause1;

  always #5 clk = ~clk;

  rst_seq #(.NCH(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .o_rst_n(rn0), .o_busy(busy0), .o_done(done0), .o_cause(cause0)
  );

  rst_seq #(.NCH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .o_rst_n(rn1), .o_busy(busy1), .o_done(done1), .o_cause(cause1)
  );

  typedef struct {
    int         t;
    logic [2:0] rn0;
    logic       b0, d0;
    logic [1:0] c0;
    logic       rn1, b1, d1;
    logic [1:0] c1;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int   t = 0;
  bit   ext_at[MAXE];
  int   last_rst = 0;
  int   last_req = 0;
  logic [1:0] m_cause = 2'b00;
  bit   armed = 1'b0;
  int   first_edge = -1;

  bit   rec_en = 1'b0;
  int   rise[3] = '{-1, -1, -1};
  int   done0_edge = -1;
  int   done1_edge = -1;

  function automatic bit sync_after(input int s);
    int j;
    j = s - SYNC + 1;
    if (j <= last_rst || j < 0) return 1'b0;
    return ext_at[j];
  endfunction

  function automatic logic [2:0] chans(input int d, input int nch, input int hold, input int gap);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 0; k < nch; k++) begin
      if (d >= hold + 1 + k * gap) r[k] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit sp, er, req;
    logic [2:0] c3, c1v;
    int d;
    t = t + 1;
    if (t < MAXE) ext_at[t] = ext_rst_n;
    if (rst) begin
      last_rst = t;
      last_req = t;
      m_cause  = 2'b00;
      armed    = 1'b0;
    end else begin
      if (first_edge < 0) first_edge = t;
      sp  = sync_after(t - 1);
      er  = !sp;
      req = er || sw_rst_req;
      if (req) begin
        last_req = t;
        if (er && armed) m_cause = 2'b01;
        else if (sw_rst_req) m_cause = 2'b10;
      end
      armed = armed | sp;
    end
    d   = t - last_req;
    c3  = chans(d, 3, 16, 4);
    c1v = chans(d, 1, 1, 1);
    e.t   = t;
    e.rn0 = c3;
    e.d0  = (c3 == 3'b111);
    e.b0  = !(c3 == 3'b111);
    e.c0  = m_cause;
    e.rn1 = c1v[0];
    e.d1  = c1v[0];
    e.b1  = !c1v[0];
    e.c1  = m_cause;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL queue_empty: monitor found no expected entry at time %0t", $time);
    end else begin
      e = q.pop_front();
      n_cmp++;
      if ({rn0, busy0, done0, cause0} !== {e.rn0, e.b0, e.d0, e.c0}) begin
        n_fail++;
        $display("FAIL dut0 edge %0d: got rst_n=%b busy=%b done=%b cause=%b, want rst_n=%b busy=%b done=%b cause=%b",
                 e.t, rn0, busy0, done0, cause0, e.rn0, e.b0, e.d0, e.c0);
      end
      n_cmp++;
      if ({rn1, busy1, done1, cause1} !== {e.rn1, e.b1, e.d1, e.c1}) begin
        n_fail++;
        $display("FAIL dut1 edge %0d: got rst_n=%b busy=%b done=%b cause=%b, want rst_n=%b busy=%b done=%b cause=%b",
                 e.t, rn1, busy1, done1, cause1, e.rn1, e.b1, e.d1, e.c1);
      end
      if (rec_en && first_edge > 0) begin
        for (int k = 0; k < 3; k++) begin
          if (rn0[k] && rise[k] < 0) rise[k] = e.t - first_edge + 1;
        end
        if (done0 && done0_edge < 0) done0_edge = e.t - first_edge + 1;
        if (done1 && done1_edge < 0) done1_edge = e.t - first_edge + 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int  ext_low_left;
    bit  found;

    rst = 1'b1; ext_rst_n = 1'b1; sw_rst_req = 1'b0;
    cyc(3);
    rst = 1'b0;
    rec_en = 1'b1;
    cyc(40);
    rec_en = 1'b0;
    chk("ch0_rise_edge", rise[0], 19);
    chk("ch1_rise_edge", rise[1], 23);
    chk("ch2_rise_edge", rise[2], 27);
    chk("done_rise_edge", done0_edge, 27);
    chk("nch1_done_edge", done1_edge, 4);
    chk("por_cause", int'(cause0), 0);
    $display("phase por: rst_n=%b done=%b cause=%b", rn0, done0, cause0);

    ext_rst_n = 1'b0;
    cyc(5);
    ext_rst_n = 1'b1;
    cyc(35);
    chk("ext_cause", int'(cause0), 1);
    $display("phase ext pulse: rst_n=%b done=%b cause=%b", rn0, done0, cause0);

    ext_rst_n = 1'b0;
    cyc(3);
    ext_rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      cyc(1);
      if (rn0 == 3'b011) found = 1'b1;
    end
    chk("reach_011_within_bound", int'(found), 1);
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    cyc(35);
    chk("sw_cause", int'(cause0), 2);
    $display("phase sw mid-release: rst_n=%b done=%b cause=%b", rn0, done0, cause0);

    ext_rst_n = 1'b0;
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    cyc(10);
    chk("both_cause", int'(cause0), 1);
    chk("both_busy_held", int'(busy0), 1);
    ext_rst_n = 1'b1;
    cyc(30);
    $display("phase ext+sw: rst_n=%b done=%b cause=%b", rn0, done0, cause0);

    ext_rst_n = 1'b0;
    cyc(2);
    ext_rst_n = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_mid_hold_rst_n", int'(rn0), 0);
    chk("rst_mid_hold_cause", int'(cause0), 0);
    cyc(40);
    $display("phase rst mid-hold: rst_n=%b done=%b cause=%b", rn0, done0, cause0);

    ext_low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      sw_rst_req = ($urandom_range(0, 59) == 0);
      if (ext_low_left == 0 && $urandom_range(0, 39) == 0)
        ext_low_left = $urandom_range(1, 8);
      ext_rst_n = (ext_low_left == 0);
      if (ext_low_left > 0) ext_low_left--;
      cyc(1);
    end
    rst = 1'b0; sw_rst_req = 1'b0; ext_rst_n = 1'b1;
    cyc(3);
    $display("phase random: done");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
